ps2_kbd: RTL

PS/2 keyboard receiver for the marsohod2 system: deserialises device-to-host frames from the keyboard pins, checks framing and odd parity, and buffers scancodes in a small FIFO. The CPU's I/O read path consumes the FIFO head, the same way the `core` memory router consumes `m32k`/`m8k`/`m4k` read data. Receive-only: the block never drives `ps2_keyb_clk`/`ps2_keyb_dat`; the top level ties those inouts to high-Z.

---
 rtl/ps2_kbd.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: synchronises the raw pins, deframes 11-bit
// device-to-host frames with odd parity, and queues good scancodes in a small FIFO.
module ps2_kbd #(
  parameter int TIMEOUT_CYC = 25000,
  parameter int FIFO_AW     = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  input  logic       clr,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       err
);

  localparam int TW    = $clog2(TIMEOUT_CYC);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          clk_sync_q, dat_sync_q;
  logic                clk_prev_q;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                parity_q, parity_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                err_q;
  logic [7:0]          mem_q [DEPTH];

  logic fall, bit_in, tmo_hit;
  logic start, shift_en, par_en, frame_ok, frame_bad, err_set;
  logic pop, full, push_ok, ovf_event;

  // Two-flop synchronisers; the extra clock flop gives the falling-edge history.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall    = clk_prev_q & ~clk_sync_q[1];
  assign bit_in  = dat_sync_q[1];
  assign tmo_hit = (state_q != IDLE) && !fall && (tmr_q == TW'(TIMEOUT_CYC - 1));

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE:    if (!bit_in) state_d = DATA;
        DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: per-edge actions
  always_comb begin
    start     = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (fall) begin
      unique case (state_q)
        IDLE:    start    = ~bit_in;
        DATA:    shift_en = 1'b1;
        PARITY:  par_en   = 1'b1;
        STOP: begin
          frame_ok  = bit_in & (^{shreg_q, parity_q});
          frame_bad = ~frame_ok;
        end
        default: ;
      endcase
    end
    err_set = frame_bad | tmo_hit;
  end

  // Deframing datapath and inter-edge timeout
  always_comb begin
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    tmr_d    = tmr_q + TW'(1);
    if (state_q == IDLE || fall || tmo_hit) tmr_d = '0;
    if (start || tmo_hit) begin
      bitcnt_d = 3'd0;
      shreg_d  = 8'h00;
    end else if (shift_en) begin
      bitcnt_d = bitcnt_q + 3'd1;
      shreg_d  = {bit_in, shreg_q[7:1]};
    end
    if (par_en) parity_d = bit_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'h00;
      parity_q <= 1'b0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      tmr_q    <= tmr_d;
      err_q    <= err_set;
    end
  end

  // FIFO control: a pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop       = rd && (count_q != '0);
  assign full      = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign push_ok   = frame_ok && (!full || pop);
  assign ovf_event = frame_ok && full && !pop;

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop     ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d    = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
    overflow_d = (overflow_q & ~clr) | ovf_event;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; zeroed pointers and count make
  // stale entries unreachable, and the array stays a plain register file.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign ready    = (count_q != '0);
  assign data     = ready ? mem_q[rd_ptr_q] : 8'h00;
  assign overflow = overflow_q;
  assign err      = err_q;

endmodule
